// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: ALU operation codes and the serial adder
// controller state encoding.
package cpu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sa_state_e;

endpackage : cpu_pkg

// File: rtl/full_adder.sv
// 1-bit full-adder cell: the single arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, through a single
// full-adder cell and a carry flip-flop. Result and flags are registered.
module serial_adder
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  sa_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_areg, w_areg_nxt;
  logic [WIDTH-1:0] r_breg, w_breg_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_zero, w_zero_nxt;

  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_sum_vec;

  full_adder u_full_adder (
    .a    (r_areg[0]),
    .b    (r_breg[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_co)
  );

  // Sum vector as it will look once this cycle's bit has shifted in.
  assign w_sum_vec = {w_fa_s, r_sreg[WIDTH-1:1]};

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_areg_nxt   = r_areg;
    w_breg_nxt   = r_breg;
    w_sreg_nxt   = r_sreg;
    w_result_nxt = r_result;
    w_cnt_nxt    = r_cnt;
    w_carry_nxt  = r_carry;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_cout_nxt   = r_cout;
    w_ovf_nxt    = r_ovf;
    w_zero_nxt   = r_zero;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and inject carry-in of 1.
          w_areg_nxt  = a;
          w_breg_nxt  = (op == OP_SUB) ? ~b : b;
          w_carry_nxt = op;
          w_cnt_nxt   = {CW{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        w_areg_nxt  = {1'b0, r_areg[WIDTH-1:1]};
        w_breg_nxt  = {1'b0, r_breg[WIDTH-1:1]};
        w_sreg_nxt  = w_sum_vec;
        w_carry_nxt = w_fa_co;
        if (r_cnt == LAST_CNT) begin
          // r_carry is the carry into the MSB on this final step.
          w_result_nxt = w_sum_vec;
          w_cout_nxt   = w_fa_co;
          w_ovf_nxt    = r_carry ^ w_fa_co;
          w_zero_nxt   = (w_sum_vec == {WIDTH{1'b0}});
          w_cnt_nxt    = {CW{1'b0}};
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_cnt_nxt    = r_cnt + CW'(1);
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_areg   <= {WIDTH{1'b0}};
      r_breg   <= {WIDTH{1'b0}};
      r_sreg   <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_areg   <= w_areg_nxt;
      r_breg   <= w_breg_nxt;
      r_sreg   <= w_sreg_nxt;
      r_result <= w_result_nxt;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_cout   <= w_cout_nxt;
      r_ovf    <= w_ovf_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int n_vec;
  int n_err;
  int cyc;
  int t0;

  // Expected values of the last completed operation (held outputs).
  logic [W-1:0] held_res;
  logic         held_cout;
  logic         held_ovf;
  logic         held_zero;

  serial_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic m_op, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    int ua, ub, sum, sa, sb, tru;
    ua  = int'(ma);
    ub  = int'(mb);
    sa  = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb  = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sum = m_op ? ua + ((1 << W) - ub) : ua + ub;
    tru = m_op ? sa - sb : sa + sb;
    r   = W'(sum % (1 << W));
    c   = (sum >= (1 << W));
    v   = (tru < -(1 << (W - 1))) || (tru > (1 << (W - 1)) - 1);
    z   = (r == '0);
  endtask

  task automatic start_op(input logic s_op, input logic [W-1:0] sa, input logic [W-1:0] sb);
    @(negedge clk);
    op    = s_op;
    a     = sa;
    b     = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    op    = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("result_held_in_run", {24'd0, result}, {24'd0, held_res});
  endtask

  task automatic wait_done(input string tag, input logic e_op, input logic [W-1:0] ea, input logic [W-1:0] eb);
    logic [W-1:0] r;
    logic c, v, z;
    model(e_op, ea, eb, r, c, v, z);
    while (!done && (cyc - t0) < 4 * W) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, 32'(cyc - t0), 32'(W));
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, {24'd0, r});
    check({tag, "_flags"}, {29'd0, cout, ovf, zero}, {29'd0, c, v, z});
    held_res  = r;
    held_cout = c;
    held_ovf  = v;
    held_zero = z;
  endtask

  task automatic run_op(input string tag, input logic r_op, input logic [W-1:0] ra, input logic [W-1:0] rb);
    start_op(r_op, ra, rb);
    wait_done(tag, r_op, ra, rb);
  endtask

  initial begin
    int n_done;
    logic        rop;
    logic [W-1:0] ra, rb;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    t0    = 0;
    held_res = '0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {20'd0, busy, done, result, cout, ovf, zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_0f_01", 1'b0, 8'h0F, 8'h01);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01);
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01);

    // Start pulsed while busy must be ignored.
    start_op(1'b0, 8'h10, 8'h20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    op    = 1'b0;
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore", 1'b0, 8'h10, 8'h20);
    // Accepted in the done cycle; a stray second done would cut latency short.
    run_op("back_to_back", 1'b0, 8'h01, 8'h01);

    // Reset mid-operation.
    start_op(1'b0, 8'h0F, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {20'd0, busy, done, result, cout, ovf, zero}, 32'd0);
    held_res = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (3 * W) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("no_done_after_reset", 32'(n_done), 32'd0);
    check("outputs_stay_zero", {20'd0, busy, done, result, cout, ovf, zero}, 32'd0);
    run_op("add_03_04", 1'b0, 8'h03, 8'h04);

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom_range(0, 3) == 0 ? ra : $urandom);
      run_op("random", rop, ra, rb);
    end

    // done must be a single-cycle pulse.
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("final_hold", {21'd0, result, cout, ovf, zero}, {21'd0, held_res, held_cout, held_ovf, held_zero});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_adder
